soc_system_pio_cmd_output: RTL and testbench
============================================

// Module: soc_system_pio_cmd_output
// PURPOSE
//  Avalon-MM write-side PIO: HPS drives a parallel output word toward the zoom datapath.
//  Also launches a one-shot valid/ready command transfer of that word, with timeout.
//  Counterpart of the switch-input PIO: HPS writes, fabric consumes.
//  Sits on the lightweight HPS-to-FPGA bridge beside the input PIOs.
// PARAMETERS
//  DATA_WIDTH      8     width of out_port / cmd_data (1..32)
//  RESET_VALUE     0     out_port value after reset
//  TIMEOUT_CYCLES  1024  cycles REQ may wait for cmd_ready; 0 = wait forever
// PORTS
//  clk         in   1           system clock
//  reset_n     in   1           asynchronous, active-low reset
//  address     in   3           Avalon word address
//  chipselect  in   1           Avalon select
//  write_n     in   1           Avalon write strobe, active-low
//  writedata   in   32          Avalon write data
//  readdata    out  32          Avalon read data, registered
//  out_port    out  DATA_WIDTH  live DATA register value
//  cmd_valid   out  1           command valid toward fabric
//  cmd_data    out  DATA_WIDTH  word latched at GO, stable while cmd_valid=1
//  cmd_ready   in   1           fabric accepts command
//  irq         out  1           level interrupt
// BEHAVIOUR
//  Reset: readdata=0, out_port=RESET_VALUE, cmd_valid=0, cmd_data=0, all CTRL/STATUS bits 0, state IDLE, irq=0.
//  Write = chipselect & ~write_n. Unused writedata bits ignored.
//  Register map:
//    0 DATA: RW, out_port
//    1 CTRL: bit0 GO (write-1 pulse, reads 0); bit1 IRQ_EN (RW)
//    2 STATUS: bit0 BUSY (RO); bit1 DONE, bit2 TIMEOUT, bit3 OVERRUN (sticky, write-1-to-clear)
//    4 OUTSET: WO, DATA |= wd
//    5 OUTCLR: WO, DATA &= ~wd
//    3, 6, 7: read 0, writes ignored
//  Read: readdata <= zero-extended mux(address) every clk, regardless of chipselect.
//    Read latency 1 cycle. WO registers read 0.
//  out_port updates the cycle after the write. A DATA write while BUSY changes out_port only, never cmd_data.
//  FSM, 2 states:
//    IDLE: GO -> cmd_data<=DATA, cnt<=0, go to REQ (cmd_valid=1 next cycle).
//    REQ: cmd_valid=1; BUSY=1.
//      cmd_ready=1 -> IDLE, cmd_valid=0 next cycle, DONE<=1.
//      Else cnt++. When cnt==TIMEOUT_CYCLES-1 and TIMEOUT_CYCLES!=0 -> IDLE, TIMEOUT<=1.
//      cmd_ready and timeout in the same cycle: ready wins; DONE set, TIMEOUT not set.
//  GO while BUSY: ignored, OVERRUN<=1, transfer in flight unaffected.
//  Sticky set and W1C clear of the same bit in the same cycle: set wins.
//  irq = IRQ_EN & (DONE | TIMEOUT | OVERRUN), driven from registers, no combinational input path.
//  Reset mid-REQ: cmd_valid drops asynchronously; no DONE/TIMEOUT is recorded.
//  cnt width = clog2(TIMEOUT_CYCLES)+1; saturates, never wraps.
// STRUCTURE
//  Shared package soc_system_pio_pkg:
//    register address localparams (ADDR_DATA..ADDR_OUTCLR)
//    STATUS/CTRL bit indices
//    FSM state encoding (IDLE=1'b0, REQ=1'b1)
//  Sub-module soc_system_pio_cmd_fsm: state, timeout counter, cmd_data latch.
//    Inputs: go, data, cmd_ready. Outputs: busy, done_pulse, timeout_pulse.
//  Register file, read mux and irq stay in the top module.
// TESTING
//  1. Reset, read addr 0/2 -> out_port=RESET_VALUE, readdata=RESET_VALUE then 0, cmd_valid=0.
//  2. Write DATA=0xA5, OUTSET 0x02, OUTCLR 0x80 -> out_port 0xA5, then 0xA7, then 0x27; each one cycle after its write.
//  3. DATA=0x3C, GO, cmd_ready after 5 cycles -> cmd_valid high 6 cycles, cmd_data=0x3C, STATUS=0x2; W1C 0x2 -> STATUS=0.
//  4. TIMEOUT_CYCLES=16, GO, cmd_ready held 0 -> cmd_valid high exactly 16 cycles, STATUS=0x4; IRQ_EN=1 -> irq=1.
//  5. GO while BUSY; write DATA=0x11 mid-REQ -> OVERRUN set, cmd_data unchanged, out_port=0x11, single transfer.
//  6. Assert reset_n=0 mid-REQ -> cmd_valid=0 immediately, STATUS=0 after release; cmd_ready on the timeout cycle -> DONE only.

Source files
------------

// File: rtl/soc_system_pio_pkg.sv
// Shared definitions for the HPS PIO blocks: register map, bit positions, command FSM encoding.
package soc_system_pio_pkg;

    localparam int unsigned AVALON_AW = 3;
    localparam int unsigned AVALON_DW = 32;

    localparam logic [AVALON_AW-1:0] ADDR_DATA   = 3'd0;
    localparam logic [AVALON_AW-1:0] ADDR_CTRL   = 3'd1;
    localparam logic [AVALON_AW-1:0] ADDR_STATUS = 3'd2;
    localparam logic [AVALON_AW-1:0] ADDR_OUTSET = 3'd4;
    localparam logic [AVALON_AW-1:0] ADDR_OUTCLR = 3'd5;

    localparam int unsigned CTRL_GO     = 0;
    localparam int unsigned CTRL_IRQ_EN = 1;

    localparam int unsigned STATUS_BUSY    = 0;
    localparam int unsigned STATUS_DONE    = 1;
    localparam int unsigned STATUS_TIMEOUT = 2;
    localparam int unsigned STATUS_OVERRUN = 3;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } cmd_state_e;

    // Sticky status flags, ordered to match STATUS bits 3..1
    typedef struct packed {
        logic overrun;
        logic timeout;
        logic done;
    } sticky_t;

    function automatic logic [AVALON_DW-1:0] status_word(input sticky_t flags, input logic busy);
        return {28'd0, flags.overrun, flags.timeout, flags.done, busy};
    endfunction

endpackage

// File: rtl/soc_system_pio_cmd_fsm.sv
// One-shot valid/ready command launcher: latches the word at GO, holds it until
// accepted or until the wait budget runs out.
module soc_system_pio_cmd_fsm
    import soc_system_pio_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  go,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  cmd_ready,
    output logic                  cmd_valid,
    output logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  busy,
    output logic                  done_pulse,
    output logic                  timeout_pulse
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    cmd_state_e       state_q;
    cmd_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             timeout_hit;

    // A zero budget disables the timeout entirely
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (go) state_d = REQ;
            REQ:     if (cmd_ready || timeout_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Ready has priority over a coincident timeout
    always_comb begin
        cmd_valid     = 1'b0;
        busy          = 1'b0;
        done_pulse    = 1'b0;
        timeout_pulse = 1'b0;
        if (state_q == REQ) begin
            cmd_valid     = 1'b1;
            busy          = 1'b1;
            done_pulse    = cmd_ready;
            timeout_pulse = !cmd_ready && timeout_hit;
        end
    end

    // Wait counter saturates rather than wrapping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            cmd_data <= '0;
        end else if (state_q == IDLE && go) begin
            cnt_q    <= '0;
            cmd_data <= data;
        end else if (state_q == REQ && cnt_q != '1) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/soc_system_pio_cmd_output.sv
// Avalon-MM output PIO with DATA/SET/CLR access, plus a one-shot command transfer
// of the DATA word with sticky completion status and a level interrupt.
module soc_system_pio_cmd_output
    import soc_system_pio_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter logic [31:0] RESET_VALUE    = 32'd0,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [AVALON_AW-1:0]  address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [AVALON_DW-1:0]  writedata,
    output logic [AVALON_DW-1:0]  readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  cmd_valid,
    output logic [DATA_WIDTH-1:0] cmd_data,
    input  logic                  cmd_ready,
    output logic                  irq
);

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  unused_wdata;

    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_d;
    logic                  irq_en_q;
    logic                  irq_en_d;
    sticky_t               sticky_q;
    sticky_t               sticky_d;
    sticky_t               sticky_clr;
    logic                  go;
    logic [AVALON_DW-1:0]  rd_mux;

    logic busy;
    logic done_pulse;
    logic timeout_pulse;

    assign wr_en        = chipselect & ~write_n;
    assign wdata        = writedata[DATA_WIDTH-1:0];
    assign unused_wdata = ^writedata;
    assign out_port     = data_q;

    // Write decode
    always_comb begin
        data_d     = data_q;
        irq_en_d   = irq_en_q;
        sticky_clr = '0;
        go         = 1'b0;
        if (wr_en) begin
            case (address)
                ADDR_DATA:   data_d = wdata;
                ADDR_CTRL: begin
                    go       = writedata[CTRL_GO];
                    irq_en_d = writedata[CTRL_IRQ_EN];
                end
                ADDR_STATUS: sticky_clr = sticky_t'(writedata[STATUS_OVERRUN:STATUS_DONE]);
                ADDR_OUTSET: data_d = data_q | wdata;
                ADDR_OUTCLR: data_d = data_q & ~wdata;
                default:     ;
            endcase
        end
    end

    // Sticky flags: a set in the same cycle as a W1C clear wins
    always_comb begin
        sticky_d.done    = done_pulse    | (sticky_q.done    & ~sticky_clr.done);
        sticky_d.timeout = timeout_pulse | (sticky_q.timeout & ~sticky_clr.timeout);
        sticky_d.overrun = (go & busy)   | (sticky_q.overrun & ~sticky_clr.overrun);
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:   rd_mux = AVALON_DW'(data_q);
            ADDR_CTRL:   rd_mux[CTRL_IRQ_EN] = irq_en_q;
            ADDR_STATUS: rd_mux = status_word(sticky_q, busy);
            default:     rd_mux = '0;
        endcase
    end

    // irq is registered from next-state values so it tracks the flags without lag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q   <= DATA_WIDTH'(RESET_VALUE);
            irq_en_q <= 1'b0;
            sticky_q <= '0;
            irq      <= 1'b0;
            readdata <= '0;
        end else begin
            data_q   <= data_d;
            irq_en_q <= irq_en_d;
            sticky_q <= sticky_d;
            irq      <= irq_en_d & (|sticky_d);
            readdata <= rd_mux;
        end
    end

    soc_system_pio_cmd_fsm #(
        .DATA_WIDTH    (DATA_WIDTH),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_cmd_fsm (
        .clk          (clk),
        .reset_n      (reset_n),
        .go           (go),
        .data         (data_q),
        .cmd_ready    (cmd_ready),
        .cmd_valid    (cmd_valid),
        .cmd_data     (cmd_data),
        .busy         (busy),
        .done_pulse   (done_pulse),
        .timeout_pulse(timeout_pulse)
    );

endmodule

// File: tb/tb_soc_system_pio_cmd_output.sv
// Bench for soc_system_pio_cmd_output: directed scenarios plus random bus/ready traffic,
// all outputs compared every cycle against a transaction-level model.
module tb_soc_system_pio_cmd_output;

    localparam int unsigned DW  = 8;
    localparam logic [31:0] RV  = 32'h5A;
    localparam int unsigned TMO = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [2:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic [DW-1:0] out_port;
    logic          cmd_valid;
    logic [DW-1:0] cmd_data;
    logic          cmd_ready;
    logic          irq;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    soc_system_pio_cmd_output #(
        .DATA_WIDTH    (DW),
        .RESET_VALUE   (RV),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port),
        .cmd_valid (cmd_valid),
        .cmd_data  (cmd_data),
        .cmd_ready (cmd_ready),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a pending command, how long it has waited, and the flag set
    logic [DW-1:0] m_data, m_cmd;
    logic [31:0]   m_rd;
    bit            m_busy, m_done, m_to, m_ovr, m_irqen, m_irq;
    int            m_wait;

    always @(posedge clk or negedge reset_n) begin
        bit         wr, go, fin_ok, fin_to;
        logic [2:0] clr;
        if (!reset_n) begin
            m_data = RV[DW-1:0]; m_cmd = '0; m_rd = '0;
            m_busy = 0; m_done = 0; m_to = 0; m_ovr = 0; m_irqen = 0; m_irq = 0;
            m_wait = 0;
        end else begin
            wr = chipselect && !write_n;
            case (address)
                3'd0:    m_rd = {24'd0, m_data};
                3'd1:    m_rd = {30'd0, m_irqen, 1'b0};
                3'd2:    m_rd = {28'd0, m_ovr, m_to, m_done, m_busy};
                default: m_rd = 32'd0;
            endcase
            go     = wr && address == 3'd1 && writedata[0];
            clr    = (wr && address == 3'd2) ? writedata[3:1] : 3'b000;
            fin_ok = m_busy && cmd_ready;
            fin_to = m_busy && !cmd_ready && TMO != 0 && (m_wait + 1 == TMO);
            m_done = fin_ok || (m_done && !clr[0]);
            m_to   = fin_to || (m_to && !clr[1]);
            m_ovr  = (go && m_busy) || (m_ovr && !clr[2]);
            if (go && !m_busy) begin
                m_busy = 1; m_cmd = m_data; m_wait = 0;
            end else if (m_busy) begin
                if (fin_ok || fin_to) m_busy = 0;
                else m_wait++;
            end
            if (wr) begin
                case (address)
                    3'd0: m_data = writedata[DW-1:0];
                    3'd1: m_irqen = writedata[1];
                    3'd4: m_data = m_data | writedata[DW-1:0];
                    3'd5: m_data = m_data & ~writedata[DW-1:0];
                    default: ;
                endcase
            end
            m_irq = m_irqen && (m_done || m_to || m_ovr);
        end
    end

    always @(negedge clk) begin
        if (reset_n && chk_en) begin
            check("readdata",  readdata,        m_rd);
            check("out_port",  32'(out_port),   32'(m_data));
            check("cmd_valid", 32'(cmd_valid),  32'(m_busy));
            check("cmd_data",  32'(cmd_data),   32'(m_cmd));
            check("irq",       32'(irq),        32'(m_irq));
        end
    end

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        address = a;
        @(negedge clk);
        d = readdata;
    endtask

    initial begin
        logic [31:0] rd;
        int n;
        reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 3'd0;
        writedata = 32'd0; cmd_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_readdata",  readdata,       32'd0);
        check("rst_out_port",  32'(out_port),  32'h5A);
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_cmd_data",  32'(cmd_data),  32'd0);
        check("rst_irq",       32'(irq),       32'd0);
        reset_n = 1'b1; chk_en = 1'b1;

        // Register reads straight out of reset
        bus_read(3'd0, rd); check("t1_rd_data", rd, 32'h5A);
        bus_read(3'd2, rd); check("t1_rd_status", rd, 32'd0);

        // DATA / OUTSET / OUTCLR
        bus_write(3'd0, 32'hFFFF_FFA5); check("t2_data",   32'(out_port), 32'hA5);
        bus_write(3'd4, 32'h0000_0002); check("t2_outset", 32'(out_port), 32'hA7);
        bus_write(3'd5, 32'h0000_0080); check("t2_outclr", 32'(out_port), 32'h27);
        bus_read(3'd5, rd); check("t2_wo_reads_0", rd, 32'd0);

        // Accepted transfer: ready on the sixth valid cycle
        bus_write(3'd0, 32'h3C);
        bus_write(3'd1, 32'h1);
        n = 0;
        repeat (5) begin if (cmd_valid) n++; @(negedge clk); end
        cmd_ready = 1'b1;
        if (cmd_valid) n++;
        check("t3_cmd_data", 32'(cmd_data), 32'h3C);
        @(negedge clk);
        cmd_ready = 1'b0;
        check("t3_valid_cycles", 32'(n), 32'd6);
        check("t3_valid_low", 32'(cmd_valid), 32'd0);
        bus_read(3'd2, rd); check("t3_status_done", rd, 32'h2);
        bus_write(3'd2, 32'h2);
        bus_read(3'd2, rd); check("t3_status_clr", rd, 32'h0);

        // Timeout after exactly TMO valid cycles
        bus_write(3'd1, 32'h1);
        n = 0;
        for (int i = 0; i < 4 * TMO && cmd_valid; i++) begin n++; @(negedge clk); end
        check("t4_valid_cycles", 32'(n), 32'd16);
        bus_read(3'd2, rd); check("t4_status_to", rd, 32'h4);
        check("t4_irq_off", 32'(irq), 32'd0);
        bus_write(3'd1, 32'h2); check("t4_irq_on", 32'(irq), 32'd1);
        bus_read(3'd1, rd); check("t4_ctrl_rd", rd, 32'h2);
        bus_write(3'd2, 32'h4); check("t4_irq_clr", 32'(irq), 32'd0);
        bus_write(3'd1, 32'h0);

        // GO and DATA write while busy
        bus_write(3'd0, 32'h77);
        bus_write(3'd1, 32'h1);
        @(negedge clk);
        bus_write(3'd1, 32'h1);
        bus_write(3'd0, 32'h11);
        check("t5_out_port", 32'(out_port), 32'h11);
        check("t5_cmd_data", 32'(cmd_data), 32'h77);
        check("t5_busy", 32'(cmd_valid), 32'd1);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        n = 0;
        repeat (TMO + 4) begin if (cmd_valid) n++; @(negedge clk); end
        check("t5_single_xfer", 32'(n), 32'd0);
        bus_read(3'd2, rd); check("t5_status", rd, 32'hA);
        bus_write(3'd2, 32'hE);

        // Asynchronous reset mid-transfer
        bus_write(3'd1, 32'h1);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check("t6_async_valid", 32'(cmd_valid), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        bus_read(3'd2, rd); check("t6_status_rst", rd, 32'h0);
        check("t6_out_port_rst", 32'(out_port), 32'h5A);

        // Ready on the last allowed cycle beats the timeout
        bus_write(3'd1, 32'h1);
        repeat (TMO - 1) @(negedge clk);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        bus_read(3'd2, rd); check("t6_race_done", rd, 32'h2);
        bus_write(3'd2, 32'hE);

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            chipselect = ($urandom_range(0, 1) == 1);
            write_n    = ($urandom_range(0, 2) == 0);
            address    = 3'($urandom_range(0, 7));
            writedata  = $urandom();
            cmd_ready  = ($urandom_range(0, 5) == 0);
            @(negedge clk);
        end
        chipselect = 1'b0; write_n = 1'b1; cmd_ready = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
